// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with a valid/ready handshake.
// A main entry (M) drives the outputs. An optional skid entry (S) catches the
// word that arrives while M is stalled, so in_ready can come from a flop.
// Also provides bubble insertion, full flush and saturating perf counters.
module pipe_stage_buf #(
  parameter int unsigned DATA_W  = 143,
  parameter int unsigned CTRL_W  = 10,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              ctrl_flush,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              acc;
  logic              pop;
  logic [CTRL_W-1:0] in_ctrl_eff;

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;

  // Current skid-entry contents; constant zero when the skid is not built.
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              s_load;

  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  assign acc         = in_valid & in_ready;
  assign pop         = m_valid_q & out_ready;
  // A bubble keeps its payload but loses every control bit.
  assign in_ctrl_eff = ctrl_flush ? '0 : in_ctrl;

  assign out_valid  = m_valid_q;
  assign out_data   = m_data_q;
  assign out_ctrl   = m_ctrl_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  // Main-entry next state: flush, then refill from S or input, then park in S.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_load    = 1'b0;
    if (flush) begin
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_ctrl_d  = '0;
    end else if (!m_valid_q || pop) begin
      if (s_valid) begin
        // S is older than anything arriving now, so it always goes first.
        m_valid_d = 1'b1;
        m_data_d  = s_data;
        m_ctrl_d  = s_ctrl;
        s_load    = acc;
      end else if (acc) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl_eff;
      end else begin
        // Payload is left stale; ctrl is cleared so an empty stage is inert.
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end else if (acc) begin
      s_load = 1'b1;
    end
  end

  // Main-entry state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
    end
  end

  if (SKID_EN) begin : gen_skid
    logic              s_valid_q;
    logic [DATA_W-1:0] s_data_q;
    logic [CTRL_W-1:0] s_ctrl_q;

    // Skid entry: captures a word while M stalls, drains into M when M frees.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s_valid_q <= 1'b0;
        s_data_q  <= '0;
        s_ctrl_q  <= '0;
      end else if (flush) begin
        s_valid_q <= 1'b0;
        s_data_q  <= '0;
        s_ctrl_q  <= '0;
      end else if (s_load) begin
        s_valid_q <= 1'b1;
        s_data_q  <= in_data;
        s_ctrl_q  <= in_ctrl_eff;
      end else if (!m_valid_q || pop) begin
        s_valid_q <= 1'b0;
      end
    end

    assign s_valid  = s_valid_q;
    assign s_data   = s_data_q;
    assign s_ctrl   = s_ctrl_q;
    // Ready depends only on the skid flop, plus the flush and reset gates.
    assign in_ready = rst & ~s_valid_q & ~flush;
  end else begin : gen_no_skid
    assign s_valid  = 1'b0;
    assign s_data   = '0;
    assign s_ctrl   = '0;
    assign in_ready = rst & (~m_valid_q | out_ready) & ~flush;
  end

  // Stall counter: saturating, clear wins, unaffected by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (m_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Bubble counter: counts accepted words converted to bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
    end else if (cnt_clr) begin
      bubble_cnt_q <= '0;
    end else if (acc && ctrl_flush && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: drives a skid (index 0) and a no-skid (index 1)
// instance with the same inputs and compares each against a queue model.
module tb_pipe_stage_buf;

  localparam int unsigned DW  = 143;
  localparam int unsigned CW  = 10;
  localparam int unsigned NW  = 4;
  localparam int unsigned SAT = 15;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;
  logic          ctrl_flush;
  logic          flush;
  logic          cnt_clr;

  logic          rdy [2];
  logic          ov  [2];
  logic [DW-1:0] od  [2];
  logic [CW-1:0] oc  [2];
  logic [NW-1:0] sc  [2];
  logic [NW-1:0] bc  [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model: each stage is a FIFO of at most two words, front = out_*.
  int            mcnt  [2];
  logic [DW-1:0] md    [2][2];
  logic [CW-1:0] mc    [2][2];
  logic [DW-1:0] mhold [2];
  int            mstall[2];
  int            mbub  [2];

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CNT_W(NW)) dut_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_ctrl(oc[0]), .ctrl_flush(ctrl_flush), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc[0]), .bubble_cnt(bc[0])
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CNT_W(NW)) dut_flat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_ctrl(oc[1]), .ctrl_flush(ctrl_flush), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc[1]), .bubble_cnt(bc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready(int k);
    if (!rst || flush) return 1'b0;
    if (k == 0) return mcnt[k] < 2;
    return (mcnt[k] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k]   = 0;
      mhold[k]  = '0;
      mstall[k] = 0;
      mbub[k]   = 0;
    end
  endtask

  task automatic model_update(int k, bit a, bit p);
    bit stalled;
    stalled = (mcnt[k] != 0) && !out_ready;
    if (cnt_clr) mstall[k] = 0;
    else if (stalled && mstall[k] < SAT) mstall[k]++;
    if (cnt_clr) mbub[k] = 0;
    else if (a && ctrl_flush && mbub[k] < SAT) mbub[k]++;
    if (flush) begin
      mcnt[k]  = 0;
      mhold[k] = '0;
    end else begin
      if (p) begin
        md[k][0] = md[k][1];
        mc[k][0] = mc[k][1];
        mcnt[k]--;
      end
      if (a) begin
        md[k][mcnt[k]] = in_data;
        mc[k][mcnt[k]] = ctrl_flush ? '0 : in_ctrl;
        mcnt[k]++;
      end
      if (mcnt[k] != 0) mhold[k] = md[k][0];
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic do_cycle();
    bit a [2];
    bit p [2];
    bit r;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      r = model_ready(k);
      check_val($sformatf("d%0d out_valid", k), 192'(ov[k]), 192'(mcnt[k] != 0));
      check_val($sformatf("d%0d out_data", k), 192'(od[k]),
                192'((mcnt[k] != 0) ? md[k][0] : mhold[k]));
      check_val($sformatf("d%0d out_ctrl", k), 192'(oc[k]),
                192'((mcnt[k] != 0) ? mc[k][0] : '0));
      check_val($sformatf("d%0d in_ready", k), 192'(rdy[k]), 192'(r));
      check_val($sformatf("d%0d stall_cnt", k), 192'(sc[k]), 192'(mstall[k]));
      check_val($sformatf("d%0d bubble_cnt", k), 192'(bc[k]), 192'(mbub[k]));
      a[k] = in_valid && r;
      p[k] = (mcnt[k] != 0) && out_ready;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, a[k], p[k]);
    #1;
  endtask

  task automatic set_in(bit v, logic [DW-1:0] d, logic [CW-1:0] c, bit cf);
    in_valid   = v;
    in_data    = d;
    in_ctrl    = c;
    ctrl_flush = cf;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("rst d%0d out_valid", k), 192'(ov[k]), 192'(0));
      check_val($sformatf("rst d%0d out_data", k), 192'(od[k]), 192'(0));
      check_val($sformatf("rst d%0d out_ctrl", k), 192'(oc[k]), 192'(0));
      check_val($sformatf("rst d%0d in_ready", k), 192'(rdy[k]), 192'(0));
      check_val($sformatf("rst d%0d counters", k), 192'({sc[k], bc[k]}), 192'(0));
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    set_in(1'b0, '0, '0, 1'b0);
    out_ready = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    model_reset();
    #2;
    async_reset();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, DW'(i), 10'h3FF, 1'b0);
      #1;
      check_val($sformatf("stream in_ready %0d", i), 192'(rdy[0]), 192'(1));
      do_cycle();
    end
    set_in(1'b0, '0, '0, 1'b0);
    do_cycle();

    // Bubble: payload kept, control cleared.
    set_in(1'b1, DW'(32'h10), 10'h2A5, 1'b1);
    do_cycle();
    set_in(1'b0, '0, '0, 1'b0);
    out_ready = 1'b0;
    #1;
    check_val("bubble out_valid", 192'(ov[0]), 192'(1));
    check_val("bubble out_data", 192'(od[0]), 192'(32'h10));
    check_val("bubble out_ctrl", 192'(oc[0]), 192'(0));
    check_val("bubble count", 192'(bc[0]), 192'(1));
    out_ready = 1'b1;
    do_cycle();

    // Backpressure: A to M, B to S, C held upstream.
    out_ready = 1'b0;
    set_in(1'b1, DW'(5), 10'h001, 1'b0);
    do_cycle();
    set_in(1'b1, DW'(6), 10'h002, 1'b0);
    do_cycle();
    set_in(1'b1, DW'(7), 10'h003, 1'b0);
    #1;
    check_val("bp in_ready after B", 192'(rdy[0]), 192'(0));
    do_cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle();
    set_in(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle();

    // Flush with both entries full; the word offered meanwhile is dropped.
    out_ready = 1'b0;
    set_in(1'b1, DW'(8), 10'h011, 1'b0);
    do_cycle();
    set_in(1'b1, DW'(9), 10'h022, 1'b0);
    do_cycle();
    set_in(1'b1, DW'(99), 10'h033, 1'b0);
    flush = 1'b1;
    do_cycle();
    flush = 1'b0;
    set_in(1'b0, '0, '0, 1'b0);
    #1;
    check_val("flush out_valid", 192'(ov[0]), 192'(0));
    check_val("flush out_data", 192'(od[0]), 192'(0));
    check_val("flush in_ready", 192'(rdy[0]), 192'(1));
    do_cycle();

    // Async reset while stalled with both entries full.
    set_in(1'b1, DW'(21), 10'h0AA, 1'b0);
    do_cycle();
    set_in(1'b1, DW'(22), 10'h0BB, 1'b0);
    do_cycle();
    set_in(1'b0, '0, '0, 1'b0);
    #2;
    async_reset();
    out_ready = 1'b1;
    set_in(1'b1, DW'(23), 10'h0CC, 1'b0);
    do_cycle();
    set_in(1'b0, '0, '0, 1'b0);
    do_cycle();

    // Counter saturation, then clear coincident with a stall.
    out_ready = 1'b0;
    set_in(1'b1, DW'(30), 10'h100, 1'b0);
    do_cycle();
    set_in(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 20; i++) do_cycle();
    check_val("stall saturated", 192'(sc[0]), 192'(SAT));
    cnt_clr = 1'b1;
    do_cycle();
    cnt_clr = 1'b0;
    check_val("stall cleared", 192'(sc[0]), 192'(0));
    do_cycle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 3) != 0),
             DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}),
             CW'($urandom()), 1'($urandom_range(0, 3) == 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 15) == 0);
      cnt_clr   = 1'($urandom_range(0, 31) == 0);
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
